// File: rtl/metronome_pkg.sv
// Shared metronome types and defaults.
// Used by the sweep and the click stage.
package metronome_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int ACCENT_HALF  = 25_000;
  localparam int NORMAL_HALF  = 50_000;
  localparam int CLICK_CYCLES = 2_500_000;

  typedef logic [2:0] beat_idx_t;

  typedef enum logic {
    IDLE,
    CLICK
  } click_state_t;

  function automatic beat_idx_t idx_inc(
    input beat_idx_t i,
    input int        bpb
  );
    if (int'(i) >= bpb - 1) return '0;
    return i + 3'd1;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Restartable square-wave divider.
// half_m1 is the half-period minus one.
module tone_divider #(
  parameter int HW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [HW-1:0] half_m1,
  output logic          wave
);

  logic          run_q,  run_d;
  logic          wave_q, wave_d;
  logic [HW-1:0] cnt_q,  cnt_d;

  always_comb begin
    run_d  = run_q;
    wave_d = wave_q;
    cnt_d  = cnt_q;
    if (load) begin
      run_d  = 1'b1;
      wave_d = 1'b1;
      cnt_d  = '0;
    end else if (clear) begin
      run_d  = 1'b0;
      wave_d = 1'b0;
      cnt_d  = '0;
    end else if (run_q) begin
      if (cnt_q == half_m1) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q  <= 1'b0;
      wave_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      wave_q <= wave_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/beat_click.sv
// Bar-aware gated click generator.
// Accent tone on beat 0, normal tone otherwise.
module beat_click #(
  parameter int BEATS_PER_BAR = 4,
  parameter int ACCENT_HALF   = metronome_pkg::ACCENT_HALF,
  parameter int NORMAL_HALF   = metronome_pkg::NORMAL_HALF,
  parameter int CLICK_CYCLES  = metronome_pkg::CLICK_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       beat,
  input  logic       enable,
  input  logic       bar_restart,
  output logic       speaker,
  output logic [2:0] beat_index,
  output logic       busy
);

  import metronome_pkg::*;

  localparam int MAXH =
    (ACCENT_HALF > NORMAL_HALF) ? ACCENT_HALF : NORMAL_HALF;
  localparam int HW =
    (MAXH > 1) ? $clog2(MAXH) : 1;
  localparam int DW =
    (CLICK_CYCLES > 1) ? $clog2(CLICK_CYCLES) : 1;

  localparam logic [HW-1:0] ACC_T = HW'(ACCENT_HALF - 1);
  localparam logic [HW-1:0] NOR_T = HW'(NORMAL_HALF - 1);
  localparam logic [DW-1:0] DUR_T = DW'(CLICK_CYCLES - 1);

  click_state_t  state_q, state_d;
  logic [DW-1:0] dur_q,   dur_d;
  logic [HW-1:0] term_q,  term_d;
  beat_idx_t     nidx_q,  nidx_d;
  beat_idx_t     bidx_q,  bidx_d;
  beat_idx_t     take;
  logic          go;
  logic          load;
  logic          clear;

  // A restart in the same cycle as a beat makes that beat the accent.
  assign take = bar_restart ? '0 : nidx_q;
  assign go   = beat && enable;

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    term_d  = term_q;
    nidx_d  = nidx_q;
    bidx_d  = bidx_q;
    load    = 1'b0;
    clear   = 1'b0;
    if (go) begin
      state_d = CLICK;
      dur_d   = '0;
      term_d  = (take == '0) ? ACC_T : NOR_T;
      bidx_d  = take;
      nidx_d  = idx_inc(take, BEATS_PER_BAR);
      load    = 1'b1;
    end else begin
      if (bar_restart) nidx_d = '0;
      case (state_q)
        IDLE: ;
        CLICK: begin
          if (!enable || dur_q == DUR_T) begin
            state_d = IDLE;
            dur_d   = '0;
            clear   = 1'b1;
          end else begin
            dur_d = dur_q + DW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dur_q   <= '0;
      term_q  <= ACC_T;
      nidx_q  <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      term_q  <= term_d;
      nidx_q  <= nidx_d;
      bidx_q  <= bidx_d;
    end
  end

  tone_divider #(
    .HW(HW)
  ) u_tone (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .clear  (clear),
    .half_m1(term_q),
    .wave   (speaker)
  );

  assign busy       = (state_q == CLICK);
  assign beat_index = bidx_q;

endmodule

// File: tb/tb_beat_click.sv
// Directed bench for beat_click.
// Small tone/click parameters for short runs.
module tb_beat_click;

  localparam int BPB = 3;
  localparam int AH  = 4;
  localparam int NH  = 8;
  localparam int CC  = 40;

  logic       clock;
  logic       reset;
  logic       beat;
  logic       enable;
  logic       bar_restart;
  logic       speaker;
  logic [2:0] beat_index;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  beat_click #(
    .BEATS_PER_BAR(BPB),
    .ACCENT_HALF  (AH),
    .NORMAL_HALF  (NH),
    .CLICK_CYCLES (CC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .beat       (beat),
    .enable     (enable),
    .bar_restart(bar_restart),
    .speaker    (speaker),
    .beat_index (beat_index),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_spk"}, speaker, 0);
  endtask

  task automatic click_check(
    input string tag,
    input int    half,
    input int    idx,
    input int    n
  );
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      if (k == 0) check({tag, "_idx"}, beat_index, idx);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_spk"}, speaker, ((k / half) % 2 == 0) ? 1 : 0);
    end
  endtask

  task automatic full_click(input string tag, input int half, input int idx);
    pulse_beat();
    click_check(tag, half, idx, CC);
    step();
    chk_idle({tag, "_end"});
  endtask

  int exp_idx[6] = '{0, 1, 2, 0, 1, 2};
  int exp_half[6] = '{AH, NH, NH, AH, NH, NH};

  initial begin
    reset       = 1'b0;
    beat        = 1'b0;
    enable      = 1'b1;
    bar_restart = 1'b0;
    step();
    step();
    chk_idle("rst");
    check("rst_idx", beat_index, 0);
    reset = 1'b1;
    while (cyc < 10) step();

    full_click("t1", AH, 0);

    bar_restart = 1'b1;
    step();
    bar_restart = 1'b0;
    chk_idle("t2_br");
    for (int b = 0; b < 6; b++) begin
      full_click($sformatf("t2_b%0d", b), exp_half[b], exp_idx[b]);
      repeat (50) step();
    end

    pulse_beat();
    click_check("t3a", AH, 0, 20);
    pulse_beat();
    click_check("t3b", NH, 1, CC);
    step();
    chk_idle("t3_end");

    bar_restart = 1'b1;
    beat        = 1'b1;
    step();
    bar_restart = 1'b0;
    beat        = 1'b0;
    click_check("t4a", AH, 0, CC);
    step();
    chk_idle("t4a_end");
    full_click("t4b", NH, 1);

    pulse_beat();
    click_check("t5a", NH, 2, 10);
    enable = 1'b0;
    step();
    chk_idle("t5_abort");
    pulse_beat();
    chk_idle("t5_mute");
    check("t5_hold", beat_index, 2);
    step();
    enable = 1'b1;
    step();
    full_click("t5_resume", AH, 0);

    pulse_beat();
    click_check("t6a", NH, 1, 10);
    #3;
    reset = 1'b0;
    #1;
    chk_idle("t6_async");
    check("t6_idx", beat_index, 0);
    step();
    step();
    reset = 1'b1;
    step();
    full_click("t6_post", AH, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
